deserialize_rx: RTL and testbench

- Receiving end of the LOAD/SHIFT serial link.
- Samples a serial bit stream framed by a load/shift marker and reassembles WIDTH-bit words.
- Presents each completed word through a valid/ready holding register, and flags framing and overrun errors.
- Sits between a serializer output and the downstream register/LED stage.

---
 rtl/deserialize_pkg.sv | 21 ++
 rtl/deserialize_shreg.sv | 35 +++
 rtl/deserialize_rx.sv | 129 ++++++++++++
 tb/tb_deserialize_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/deserialize_pkg.sv
// Shared types and constants for the LOAD/SHIFT serial receiver.
// DESERIALIZE_RX_PARITY_EN adds one trailing even-parity bit to every frame.
package deserialize_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

`ifdef DESERIALIZE_RX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Wide enough to hold the longest frame length (WIDTH+1) without wrap.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/deserialize_shreg.sv
// WIDTH-bit capture register; next_o exposes the post-edge value so the word
// can be registered downstream on the same edge that samples its last bit.
module deserialize_shreg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_i,
  input  logic             restart_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] base;

  always_comb begin
    base   = restart_i ? '0 : data_q;
    data_d = data_q;
    if (restart_i || shift_i) begin
      if (MSB_FIRST) data_d = {base[WIDTH-2:0], bit_i};
      else           data_d = {bit_i, base[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign next_o = data_d;

endmodule

// File: rtl/deserialize_rx.sv
// Serial frame receiver: FSM, bit counter, valid/ready holding register and
// sticky error flags. Parity checking is enabled by DESERIALIZE_RX_PARITY_EN.
module deserialize_rx
  import deserialize_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int CW        = cnt_width(WIDTH)
) (
  input  logic             input_clock1_clk_1,
  input  logic             input_push_button1_reset_1,
  input  logic             input_shift_en,
  input  logic             input_serial_data,
  input  logic             input_load_shift,
  input  logic             input_ready,
  input  logic             input_clear_flags,
  output logic [WIDTH-1:0] output_word,
  output logic             output_valid,
  output logic             output_busy,
  output logic [CW-1:0]    output_bit_count,
  output logic             output_framing_error,
  output logic             output_overrun,
  output logic             output_parity_error
);

  localparam int FL = WIDTH + PARITY_BITS;
  localparam logic [CW-1:0] LAST_CNT = CW'(FL - 1);
  localparam logic [CW-1:0] DATA_CNT = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             ovr_q, ovr_d;
  logic             par_q, par_d;
  logic             ovr_set;

  logic             strobe_start, strobe_bit, shift_data, complete, cand_par;
  logic [WIDTH-1:0] shreg_next;

  // A load_shift strobe restarts capture whether idle or mid-frame.
  assign strobe_start = input_shift_en & input_load_shift;
  assign strobe_bit   = input_shift_en & ~input_load_shift & (state_q == SHIFT);
  assign shift_data   = strobe_bit & (count_q < DATA_CNT);
  assign complete     = strobe_bit & (count_q == LAST_CNT);

`ifdef DESERIALIZE_RX_PARITY_EN
  // On the parity strobe the register holds, so shreg_next is the data word.
  assign cand_par = ^shreg_next ^ input_serial_data;
`else
  assign cand_par = 1'b0;
`endif

  deserialize_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk_i    (input_clock1_clk_1),
    .rst_i    (input_push_button1_reset_1),
    .shift_i  (shift_data),
    .restart_i(strobe_start),
    .bit_i    (input_serial_data),
    .next_o   (shreg_next)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    valid_d = valid_q;
    par_d   = par_q;
    ovr_set = 1'b0;

    if (strobe_start) begin
      state_d = SHIFT;
      count_d = CW'(1);
    end else if (complete) begin
      state_d = IDLE;
      count_d = '0;
    end else if (strobe_bit) begin
      count_d = count_q + CW'(1);
    end

    if (complete) begin
      if (!valid_q || input_ready) begin
        word_d  = shreg_next;
        par_d   = cand_par;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (valid_q && input_ready) begin
      valid_d = 1'b0;
    end

    fe_d  = (fe_q & ~input_clear_flags) | (strobe_start & (state_q == SHIFT));
    ovr_d = (ovr_q & ~input_clear_flags) | ovr_set;
  end

  always_ff @(posedge input_clock1_clk_1 or posedge input_push_button1_reset_1) begin
    if (input_push_button1_reset_1) begin
      state_q <= IDLE;
      count_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
      par_q   <= par_d;
    end
  end

  assign output_word          = word_q;
  assign output_valid         = valid_q;
  assign output_busy          = (state_q == SHIFT);
  assign output_bit_count     = count_q;
  assign output_framing_error = fe_q;
  assign output_overrun       = ovr_q;
  assign output_parity_error  = par_q;

endmodule

// File: tb/tb_deserialize_rx.sv
// Bench for deserialize_rx: directed scenarios plus randomized strobes checked
// against a queue-based frame model.
module tb_deserialize_rx;
  import deserialize_pkg::*;

  localparam int W   = 4;
  localparam bit MSB = 1'b1;
  localparam int CW  = cnt_width(W);
  localparam int FL  = W + PARITY_BITS;
  localparam int OW  = W + CW + 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, sd = 1'b0, ls = 1'b0, rdy = 1'b1, clr = 1'b0;
  logic [W-1:0]  o_word;
  logic          o_valid, o_busy, o_fe, o_ovr, o_par;
  logic [CW-1:0] o_cnt;

  int pass_cnt = 0;
  int total    = 0;

  bit         mq[$];
  logic [W-1:0] m_word = '0;
  bit         m_valid = 0, m_fe = 0, m_ovr = 0, m_par = 0;

  logic [OW-1:0] obs, expv;
  assign obs = {o_word, o_valid, o_busy, o_cnt, o_fe, o_ovr, o_par};

  deserialize_rx #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
    .input_clock1_clk_1        (clk),
    .input_push_button1_reset_1(rst),
    .input_shift_en            (en),
    .input_serial_data         (sd),
    .input_load_shift          (ls),
    .input_ready               (rdy),
    .input_clear_flags         (clr),
    .output_word               (o_word),
    .output_valid              (o_valid),
    .output_busy               (o_busy),
    .output_bit_count          (o_cnt),
    .output_framing_error      (o_fe),
    .output_overrun            (o_ovr),
    .output_parity_error       (o_par)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_word = '0; m_valid = 0; m_fe = 0; m_ovr = 0; m_par = 0;
  endtask

  task automatic build_exp();
    logic [CW-1:0] c;
    c = CW'(mq.size());
    expv = {m_word, m_valid, (mq.size() != 0), c, m_fe, m_ovr, m_par};
  endtask

  // Drive one cycle of inputs, advance the model by the frame rules, step the clock.
  task automatic cyc(input logic e, input logic s, input logic l, input logic r, input logic c);
    bit comp, fe_set, ov_set, p;
    logic [W-1:0] w;
    en = e; sd = s; ls = l; rdy = r; clr = c;
    comp = 0; fe_set = 0; ov_set = 0; p = 0; w = '0;
    if (e) begin
      if (l) begin
        if (mq.size() != 0) fe_set = 1;
        mq.delete();
        mq.push_back(s);
      end else if (mq.size() != 0) begin
        mq.push_back(s);
      end
      if (mq.size() == FL) begin
        comp = 1;
        for (int i = 0; i < W; i++) begin
          if (MSB) w[W-1-i] = mq[i];
          else     w[i]     = mq[i];
        end
        if (PARITY_BITS == 1) foreach (mq[k]) p = p ^ mq[k];
        mq.delete();
      end
    end
    if (comp && (!m_valid || r)) begin
      m_word = w; m_valid = 1; m_par = p;
    end else if (comp) begin
      ov_set = 1;
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    m_fe  = (m_fe && !c) || fe_set;
    m_ovr = (m_ovr && !c) || ov_set;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input bit gaps, input logic r, input bit pflip);
    for (int i = 0; i < W; i++) begin
      cyc(1'b1, MSB ? d[W-1-i] : d[i], (i == 0), r, 1'b0);
      if (gaps && (i != W-1 || PARITY_BITS == 1)) cyc(1'b0, 1'b0, 1'b0, r, 1'b0);
    end
    if (PARITY_BITS == 1) cyc(1'b1, (^d) ^ pflip, 1'b0, r, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #12;
    total++;
    if (obs !== '0) $display("FAIL reset_outputs: got %h want 0", obs);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_continuous();
    send_frame(4'hB, 1'b0, 1'b1, 1'b0);
    total++;
    if ({o_word, o_valid, o_busy, o_cnt} !== {4'hB, 1'b1, 1'b0, 3'd0})
      $display("FAIL cont_word: got word=%h valid=%b busy=%b cnt=%0d want B/1/0/0", o_word, o_valid, o_busy, o_cnt);
    else pass_cnt++;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (o_valid !== 1'b0) $display("FAIL cont_valid_drop: got %b want 0", o_valid);
    else pass_cnt++;
  endtask

  task automatic test_gapped();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if ({o_busy, o_cnt} !== {1'b1, 3'd1}) $display("FAIL gap_hold1: got busy=%b cnt=%0d want 1/1", o_busy, o_cnt);
    else pass_cnt++;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    total++;
    if (o_cnt !== 3'd2) $display("FAIL gap_hold2: got cnt=%0d want 2", o_cnt);
    else pass_cnt++;
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    if (PARITY_BITS == 1) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    total++;
    if ({o_word, o_valid} !== {4'hB, 1'b1}) $display("FAIL gap_word: got word=%h valid=%b want B/1", o_word, o_valid);
    else pass_cnt++;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    send_frame(4'hB, 1'b0, 1'b0, 1'b0);
    send_frame(4'h6, 1'b0, 1'b0, 1'b0);
    total++;
    if ({o_word, o_valid, o_ovr} !== {4'hB, 1'b1, 1'b1})
      $display("FAIL overrun: got word=%h valid=%b ovr=%b want B/1/1", o_word, o_valid, o_ovr);
    else pass_cnt++;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if ({o_ovr, o_valid} !== 2'b00) $display("FAIL overrun_clear: got ovr=%b valid=%b want 0/0", o_ovr, o_valid);
    else pass_cnt++;
  endtask

  task automatic test_framing();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if ({o_fe, o_cnt, o_busy} !== {1'b1, 3'd1, 1'b1})
      $display("FAIL framing_restart: got fe=%b cnt=%0d busy=%b want 1/1/1", o_fe, o_cnt, o_busy);
    else pass_cnt++;
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    if (PARITY_BITS == 1) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if ({o_word, o_fe} !== {4'h6, 1'b1}) $display("FAIL framing_word: got word=%h fe=%b want 6/1", o_word, o_fe);
    else pass_cnt++;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midframe();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (obs !== '0) $display("FAIL midframe_reset: got %h want 0", obs);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(4'h3, 1'b0, 1'b1, 1'b0);
    total++;
    if ({o_word, o_valid} !== {4'h3, 1'b1}) $display("FAIL post_reset_word: got word=%h valid=%b want 3/1", o_word, o_valid);
    else pass_cnt++;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_parity();
    send_frame(4'hB, 1'b0, 1'b1, 1'b0);
    total++;
    if ({o_word, o_par} !== {4'hB, 1'b0}) $display("FAIL parity_good: got word=%h par=%b want B/0", o_word, o_par);
    else pass_cnt++;
    send_frame(4'hB, 1'b0, 1'b1, 1'b1);
`ifdef DESERIALIZE_RX_PARITY_EN
    total++;
    if ({o_word, o_par} !== {4'hB, 1'b1}) $display("FAIL parity_bad: got word=%h par=%b want B/1", o_word, o_par);
    else pass_cnt++;
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(7) == 0),
          ($urandom_range(2) != 0), ($urandom_range(15) == 0));
      build_exp();
      total++;
      if (obs !== expv) $display("FAIL random_cycle%0d: got %h want %h", n, obs, expv);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    send_frame(4'h5, 1'b0, 1'b1, 1'b0);
    send_frame(4'hA, 1'b0, 1'b1, 1'b0);
    build_exp();
    total++;
    if ({o_word, o_valid, o_fe, o_ovr} !== {4'hA, 1'b1, m_fe, m_ovr})
      $display("FAIL back_to_back: got word=%h valid=%b fe=%b ovr=%b want A/1/%b/%b", o_word, o_valid, o_fe, o_ovr, m_fe, m_ovr);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gapped();
    test_overrun();
    test_framing();
    test_reset_midframe();
    test_parity();
    test_random();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d passed so far", pass_cnt, total);
    $fatal(1);
  end

endmodule
